power_op_issuer: RTL and testbench

// Initiator side of the scalar-field power-calculator interface. Accepts (i, it, n, tag)

---
 rtl/power_op_pkg.sv | 37 +++
 rtl/power_op_fifo.sv | 62 ++++++
 rtl/power_op_issuer.sv | 145 ++++++++++++++
 tb/tb_power_op_issuer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/power_op_pkg.sv
// Shared types for the power-op issuer: operand record, FSM states and scalar packing.
// No logic; the latency and backpressure behaviour live in power_op_fifo and power_op_issuer.
// Widths here are the defaults the top level checks its parameters against.
package power_op_pkg;

    localparam int DEF_FIELD_W     = 8;
    localparam int DEF_SCALAR_SIZE = 3 * DEF_FIELD_W;
    localparam int DEF_TAG_W       = 4;

    localparam int N_LSB  = 0;
    localparam int IT_LSB = DEF_FIELD_W;
    localparam int I_LSB  = 2 * DEF_FIELD_W;

    typedef struct packed {
        logic [DEF_FIELD_W-1:0] i;
        logic [DEF_FIELD_W-1:0] it;
        logic [DEF_FIELD_W-1:0] n;
        logic [DEF_TAG_W-1:0]   tag;
    } power_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESPOND
    } issuer_state_e;

    function automatic logic [DEF_SCALAR_SIZE-1:0] pack_scalar(input power_op_t op);
        logic [DEF_SCALAR_SIZE-1:0] s;
        s = '0;
        s[I_LSB  +: DEF_FIELD_W] = op.i;
        s[IT_LSB +: DEF_FIELD_W] = op.it;
        s[N_LSB  +: DEF_FIELD_W] = op.n;
        return s;
    endfunction

endpackage

// File: rtl/power_op_fifo.sv
// DEPTH-entry FIFO of power_op_t with count, full and empty flags.
// Write visible at the head one cycle after push; read data is the combinational head.
// Push while full and pop while empty are ignored; no bypass from push to pop.
module power_op_fifo
    import power_op_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  power_op_t              wr_data,
    input  logic                   pop,
    output power_op_t              rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    power_op_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/power_op_issuer.sv
// Queues power-op requests and issues them one at a time to the scalar-field calculator.
// Idle accept to calc_start is 2 cycles; response is valid CALC_LATENCY+3 cycles after accept.
// req_ready drops when the queue is full; a held response stalls all further issue.
module power_op_issuer
    import power_op_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int SCALAR_SIZE  = DEF_SCALAR_SIZE,
    parameter int FIELD_W      = DEF_FIELD_W,
    parameter int DEPTH        = 4,
    parameter int CALC_LATENCY = 2,
    parameter int TAG_W        = DEF_TAG_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [FIELD_W-1:0]     req_i,
    input  logic [FIELD_W-1:0]     req_it,
    input  logic [FIELD_W-1:0]     req_n,
    input  logic [TAG_W-1:0]       req_tag,
    output logic [SCALAR_SIZE-1:0] scalar_field,
    output logic                   calc_start,
    input  logic [WIDTH-1:0]       calc_result,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_result,
    output logic [TAG_W-1:0]       rsp_tag,
    output logic                   rsp_zero_exp,
    output logic                   busy
);

    if (SCALAR_SIZE != 3 * FIELD_W) begin : g_chk_scalar
        $error("power_op_issuer: SCALAR_SIZE must equal 3*FIELD_W");
    end
    if (FIELD_W != DEF_FIELD_W || TAG_W != DEF_TAG_W) begin : g_chk_pkg
        $error("power_op_issuer: FIELD_W/TAG_W must match power_op_pkg");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
        $error("power_op_issuer: DEPTH must be a power of two >= 2");
    end
    if (CALC_LATENCY < 1) begin : g_chk_lat
        $error("power_op_issuer: CALC_LATENCY must be >= 1");
    end

    localparam int LAT_W = $clog2(CALC_LATENCY + 1);

    issuer_state_e          state_q;
    issuer_state_e          state_d;
    power_op_t              op_q;
    power_op_t              fifo_wr;
    power_op_t              fifo_rd;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [LAT_W-1:0]       lat_q;
    logic                   capture;
    logic [WIDTH-1:0]       rsp_result_q;
    logic                   rsp_zero_q;

    assign req_ready = !fifo_full;
    assign fifo_push = req_valid && req_ready;
    assign fifo_wr   = '{i: req_i, it: req_it, n: req_n, tag: req_tag};

    power_op_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .wr_data (fifo_wr),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        fifo_pop   = 1'b0;
        capture    = 1'b0;
        calc_start = 1'b0;
        rsp_valid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                calc_start = 1'b1;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_q == '0) begin
                    capture = 1'b1;
                    state_d = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // op_q only changes on a pop, so scalar_field and rsp_tag hold from ISSUE through IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            lat_q        <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (fifo_pop) begin
                op_q <= fifo_rd;
            end
            if (state_q == ST_ISSUE) begin
                lat_q <= LAT_W'(CALC_LATENCY - 1);
            end else if (state_q == ST_WAIT && lat_q != '0) begin
                lat_q <= lat_q - 1'b1;
            end
            if (capture) begin
                rsp_result_q <= calc_result;
                rsp_zero_q   <= (op_q.n == '0);
            end
        end
    end

    assign scalar_field = pack_scalar(op_q);
    assign rsp_result   = rsp_result_q;
    assign rsp_tag      = op_q.tag;
    assign rsp_zero_exp = rsp_zero_q;
    assign busy         = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_power_op_issuer.sv
// Directed and randomised checks of power_op_issuer against a behavioural calculator.
module tb_power_op_issuer;

    localparam int WIDTH = 32;
    localparam int SS    = 24;
    localparam int FW    = 8;
    localparam int DEPTH = 4;
    localparam int LAT   = 2;
    localparam int TW    = 4;

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [FW-1:0] req_i;
    logic [FW-1:0] req_it;
    logic [FW-1:0] req_n;
    logic [TW-1:0] req_tag;
    logic [SS-1:0] scalar_field;
    logic          calc_start;
    logic [31:0]   calc_result;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_result;
    logic [TW-1:0] rsp_tag;
    logic          rsp_zero_exp;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    power_op_issuer #(
        .WIDTH(WIDTH), .SCALAR_SIZE(SS), .FIELD_W(FW),
        .DEPTH(DEPTH), .CALC_LATENCY(LAT), .TAG_W(TW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_i(req_i), .req_it(req_it), .req_n(req_n), .req_tag(req_tag),
        .scalar_field(scalar_field), .calc_start(calc_start), .calc_result(calc_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_tag(rsp_tag), .rsp_zero_exp(rsp_zero_exp), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // result = (i * n * it^(n-1))^n mod 2^32; n == 0 gives 0
    function automatic logic [31:0] calc_model(input logic [7:0] i, input logic [7:0] it,
                                               input logic [7:0] n);
        logic [31:0] base;
        logic [31:0] r;
        base = 32'(i) * 32'(n);
        for (int k = 1; k < int'(n); k++) base = base * 32'(it);
        r = 32'd1;
        for (int k = 0; k < int'(n); k++) r = r * base;
        if (n == 8'd0) r = 32'd0;
        return r;
    endfunction

    // Calculator: result is driven only during the cycle CALC_LATENCY after calc_start.
    bit          pipe_v [LAT];
    logic [31:0] pipe_d [LAT];
    always @(negedge clk) begin
        calc_result = pipe_v[LAT-1] ? pipe_d[LAT-1] : 32'hDEAD_BEEF;
        for (int k = LAT - 1; k > 0; k--) begin
            pipe_v[k] = pipe_v[k-1];
            pipe_d[k] = pipe_d[k-1];
        end
        pipe_v[0] = calc_start;
        pipe_d[0] = calc_model(scalar_field[23:16], scalar_field[15:8], scalar_field[7:0]);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [7:0] i, input logic [7:0] it, input logic [7:0] n,
                             input logic [3:0] tag);
        req_valid = 1'b1;
        req_i = i; req_it = it; req_n = n; req_tag = tag;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick; tick;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
        n_checks++; if (calc_start !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_ctrl got start=%b vld=%b busy=%b exp=0,0,0", calc_start, rsp_valid, busy); end
        n_checks++; if (scalar_field !== 24'h0 || rsp_result !== 32'h0 || rsp_tag !== 4'h0 || rsp_zero_exp !== 1'b0) begin
            n_fail++; $display("FAIL rst_data got sf=%h res=%h tag=%h z=%b exp=0", scalar_field, rsp_result, rsp_tag, rsp_zero_exp); end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_single(input string name, input logic [7:0] i, input logic [7:0] it,
                               input logic [7:0] n, input logic [3:0] tag,
                               input logic [23:0] exp_sf, input logic [31:0] exp_res,
                               input logic exp_z);
        rsp_ready = 1'b1;
        drive_req(i, it, n, tag);
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL %s_accept req_ready=%b exp=1", name, req_ready); end
        tick;
        req_valid = 1'b0;
        n_checks++; if (calc_start !== 1'b0) begin n_fail++; $display("FAIL %s_start_t1 got=%b exp=0", name, calc_start); end
        tick;
        n_checks++; if (calc_start !== 1'b1) begin n_fail++; $display("FAIL %s_start_t2 got=%b exp=1", name, calc_start); end
        n_checks++; if (scalar_field !== exp_sf) begin n_fail++; $display("FAIL %s_scalar got=%h exp=%h", name, scalar_field, exp_sf); end
        for (int k = 0; k < LAT; k++) begin
            tick;
            n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL %s_early_rsp cyc=%0d got=1 exp=0", name, k); end
        end
        tick;
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL %s_rsp_valid got=%b exp=1", name, rsp_valid); end
        n_checks++; if (rsp_result !== exp_res) begin n_fail++; $display("FAIL %s_result got=%0d exp=%0d", name, rsp_result, exp_res); end
        n_checks++; if (rsp_tag !== tag || rsp_zero_exp !== exp_z) begin
            n_fail++; $display("FAIL %s_tag_z got=%h/%b exp=%h/%b", name, rsp_tag, rsp_zero_exp, tag, exp_z); end
        tick;
        n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || scalar_field !== exp_sf) begin
            n_fail++; $display("FAIL %s_idle got vld=%b busy=%b sf=%h exp 0,0,%h", name, rsp_valid, busy, scalar_field, exp_sf); end
    endtask

    task automatic test_back_to_back;
        logic [7:0]  vi [5];
        logic [7:0]  vit [5];
        logic [7:0]  vn [5];
        logic [3:0]  vt [5];
        logic [31:0] vr [5];
        bit          got;
        vi  = '{8'd1, 8'd3, 8'd2, 8'd5, 8'd4};
        vit = '{8'd2, 8'd2, 8'd2, 8'd9, 8'd1};
        vn  = '{8'd1, 8'd2, 8'd3, 8'd1, 8'd0};
        vt  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd6};
        vr  = '{32'd1, 32'd144, 32'd13824, 32'd5, 32'd0};
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive_req(vi[k], vit[k], vn[k], vt[k]);
            n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready op=%0d got=0 exp=1", k); end
            tick;
        end
        req_valid = 1'b0;
        n_checks++; if (req_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL b2b_full got ready=%b busy=%b exp 0,1", req_ready, busy); end
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            got = 1'b0;
            for (int c = 0; c < 20 && !got; c++) begin
                if (rsp_valid) got = 1'b1; else tick;
            end
            n_checks++;
            if (!got) begin
                n_fail++; $display("FAIL b2b_timeout op=%0d rsp_valid=0 exp=1", k);
            end else if (rsp_result !== vr[k] || rsp_tag !== vt[k] || rsp_zero_exp !== (vn[k] == 8'd0)) begin
                n_fail++; $display("FAIL b2b_rsp op=%0d got res=%0d tag=%0d z=%b exp res=%0d tag=%0d z=%b",
                                   k, rsp_result, rsp_tag, rsp_zero_exp, vr[k], vt[k], vn[k] == 8'd0);
            end
            tick;
        end
    endtask

    task automatic test_rsp_stall;
        bit got;
        rsp_ready = 1'b0;
        drive_req(8'd6, 8'd3, 8'd1, 4'd9);
        tick;
        drive_req(8'd1, 8'd1, 8'd1, 4'd10);
        tick;
        req_valid = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (rsp_valid) got = 1'b1; else tick;
        end
        n_checks++; if (!got) begin n_fail++; $display("FAIL stall_timeout rsp_valid=0 exp=1"); end
        for (int c = 0; c < 10; c++) begin
            tick;
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_result !== 32'd6 || rsp_tag !== 4'd9 || rsp_zero_exp !== 1'b0 || calc_start !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold cyc=%0d got vld=%b res=%0d tag=%0d z=%b start=%b exp 1,6,9,0,0",
                                   c, rsp_valid, rsp_result, rsp_tag, rsp_zero_exp, calc_start);
            end
        end
        rsp_ready = 1'b1;
        tick;
        n_checks++; if (rsp_valid !== 1'b0 || calc_start !== 1'b0) begin
            n_fail++; $display("FAIL stall_release_t1 got vld=%b start=%b exp 0,0", rsp_valid, calc_start); end
        tick;
        n_checks++; if (calc_start !== 1'b1 || scalar_field !== 24'h010101) begin
            n_fail++; $display("FAIL stall_release_t2 got start=%b sf=%h exp 1,010101", calc_start, scalar_field); end
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (rsp_valid) got = 1'b1; else tick;
        end
        n_checks++; if (!got || rsp_result !== 32'd1 || rsp_tag !== 4'd10) begin
            n_fail++; $display("FAIL stall_second got vld=%b res=%0d tag=%0d exp 1,1,10", rsp_valid, rsp_result, rsp_tag); end
        tick;
    endtask

    task automatic test_reset_in_flight;
        bit seen;
        rsp_ready = 1'b1;
        drive_req(8'd2, 8'd2, 8'd2, 4'd11); tick;
        drive_req(8'd3, 8'd3, 8'd3, 4'd12); tick;
        drive_req(8'd4, 8'd4, 8'd4, 4'd13); tick;
        req_valid = 1'b0;
        n_checks++; if (calc_start !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL rif_wait got start=%b vld=%b busy=%b exp 0,0,1", calc_start, rsp_valid, busy); end
        reset = 1'b1;
        #1;
        n_checks++; if (req_ready !== 1'b1 || busy !== 1'b0 || calc_start !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL rif_ctrl got ready=%b busy=%b start=%b vld=%b exp 1,0,0,0", req_ready, busy, calc_start, rsp_valid); end
        n_checks++; if (scalar_field !== 24'h0 || rsp_result !== 32'h0 || rsp_tag !== 4'h0 || rsp_zero_exp !== 1'b0) begin
            n_fail++; $display("FAIL rif_data got sf=%h res=%h tag=%h z=%b exp 0", scalar_field, rsp_result, rsp_tag, rsp_zero_exp); end
        tick;
        reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick;
            if (rsp_valid !== 1'b0 || calc_start !== 1'b0) seen = 1'b1;
        end
        n_checks++; if (seen) begin n_fail++; $display("FAIL rif_ghost got activity=1 exp=0"); end
        test_single("rif_next", 8'h11, 8'h01, 8'h03, 4'hA, 24'h110103, 32'd132651, 1'b0);
    endtask

    task automatic test_random;
        logic [31:0] q_res [$];
        logic [3:0]  q_tag [$];
        bit          q_z [$];
        int          outstanding;
        int          accepted;
        outstanding = 0;
        accepted = 0;
        for (int c = 0; c < 10000 + 200; c++) begin
            if (c < 10000) begin
                req_valid = ($urandom_range(0, 1) == 1);
                req_i     = 8'($urandom);
                req_it    = 8'($urandom);
                req_n     = 8'($urandom_range(0, 4));
                req_tag   = 4'($urandom);
                rsp_ready = ($urandom_range(0, 3) != 0);
            end else begin
                req_valid = 1'b0;
                rsp_ready = 1'b1;
            end
            if (req_valid && req_ready) begin
                q_res.push_back(calc_model(req_i, req_it, req_n));
                q_tag.push_back(req_tag);
                q_z.push_back(req_n == 8'd0);
                outstanding++;
                accepted++;
            end
            if (rsp_valid && rsp_ready) begin
                n_checks++;
                if (q_res.size() == 0) begin
                    n_fail++; $display("FAIL rnd_spurious cyc=%0d got rsp tag=%0d exp none", c, rsp_tag);
                end else begin
                    if (rsp_result !== q_res[0] || rsp_tag !== q_tag[0] || rsp_zero_exp !== q_z[0]) begin
                        n_fail++; $display("FAIL rnd_rsp cyc=%0d got res=%h tag=%0d z=%b exp res=%h tag=%0d z=%b",
                                           c, rsp_result, rsp_tag, rsp_zero_exp, q_res[0], q_tag[0], q_z[0]);
                    end
                    void'(q_res.pop_front());
                    void'(q_tag.pop_front());
                    void'(q_z.pop_front());
                    outstanding--;
                end
            end
            if (c % 100 == 0) begin
                n_checks++;
                if (outstanding > DEPTH + 1) begin
                    n_fail++; $display("FAIL rnd_overflow cyc=%0d outstanding=%0d exp<=%0d", c, outstanding, DEPTH + 1);
                end
            end
            tick;
        end
        req_valid = 1'b0;
        n_checks++; if (q_res.size() != 0 || busy !== 1'b0 || accepted < 2 * DEPTH) begin
            n_fail++; $display("FAIL rnd_drain got left=%0d busy=%b accepted=%0d exp 0,0,>=%0d", q_res.size(), busy, accepted, 2 * DEPTH); end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_i = '0; req_it = '0; req_n = '0; req_tag = '0;
        rsp_ready = 1'b0;
        test_reset;
        test_single("single", 8'd2, 8'd3, 8'd2, 4'd5, 24'h020302, 32'd144, 1'b0);
        test_single("zero_exp", 8'd9, 8'd7, 8'd0, 4'd3, 24'h090700, 32'd0, 1'b1);
        test_back_to_back;
        test_rsp_stall;
        test_reset_in_flight;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
